// File: rtl/led_share_arbiter.sv
// Round-robin time-share of the 4 board LEDs between NUM_CLIENTS requesters with a minimum dwell per owner.
// Optional owner-ID flash on every new grant when LED_SHARE_ARB_OWNER_FLASH_EN is defined.
module led_share_arbiter #(
  parameter int NUM_CLIENTS  = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int DWELL_W      = 26,
  parameter int FLASH_CYCLES = 12500000
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_CLIENTS-1:0]     req,
  input  logic [4*NUM_CLIENTS-1:0]   req_val,
  output logic [NUM_CLIENTS-1:0]     grant,
  output logic [3:0]                 led_out,
  output logic                       busy
);

  localparam int                PTR_W      = $clog2(NUM_CLIENTS);
  localparam logic [PTR_W:0]    NUM_W      = (PTR_W+1)'(NUM_CLIENTS);
  localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(NUM_CLIENTS-1);
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES-1);

`ifdef LED_SHARE_ARB_OWNER_FLASH_EN
  localparam int                 FLASH_W    = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES-1);
  typedef enum logic [1:0] {IDLE, SHOW, FLASH} state_t;
  logic [FLASH_W-1:0] flash_q, flash_d;
`else
  typedef enum logic [0:0] {IDLE, SHOW} state_t;
`endif

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [PTR_W-1:0]       rr_q, rr_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [3:0]             led_q, led_d;
  logic                   busy_q, busy_d;
  logic [DWELL_W-1:0]     dwell_q, dwell_d;

  logic                   arb_found;
  logic [PTR_W-1:0]       arb_sel;
  logic [PTR_W:0]         arb_sum;
  logic [NUM_CLIENTS-1:0] sel_onehot;
  logic [PTR_W-1:0]       rr_after;
  logic                   owner_req;
  logic [3:0]             owner_vec;

  // rr_q always sits one past the owner, so scanning from it finds "first after owner" with the owner last
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_sum   = '0;
    for (int k = NUM_CLIENTS-1; k >= 0; k--) begin
      arb_sum = {1'b0, rr_q} + (PTR_W+1)'(k);
      if (arb_sum >= NUM_W) arb_sum = arb_sum - NUM_W;
      if (req[arb_sum[PTR_W-1:0]]) begin
        arb_found = 1'b1;
        arb_sel   = arb_sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_onehot          = '0;
    sel_onehot[arb_sel] = 1'b1;
    rr_after            = (arb_sel == LAST_IDX) ? '0 : arb_sel + PTR_W'(1);
    owner_req           = req[owner_q];
    owner_vec           = req_val[{owner_q, 2'b00} +: 4];
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    led_d   = led_q;
    busy_d  = busy_q;
    dwell_d = dwell_q;
`ifdef LED_SHARE_ARB_OWNER_FLASH_EN
    flash_d = flash_q;
`endif
    case (state_q)
      IDLE: begin
        grant_d = '0;
        led_d   = '0;
        busy_d  = 1'b0;
        if (arb_found) begin
          owner_d = arb_sel;
          grant_d = sel_onehot;
          busy_d  = 1'b1;
          rr_d    = rr_after;
          dwell_d = DWELL_LOAD;
`ifdef LED_SHARE_ARB_OWNER_FLASH_EN
          state_d = FLASH;
          flash_d = FLASH_LOAD;
`else
          state_d = SHOW;
`endif
        end
      end
      SHOW: begin
        led_d = owner_vec;
        if (!owner_req || dwell_q == '0) begin
          if (!arb_found) begin
            state_d = IDLE;
            grant_d = '0;
            led_d   = '0;
            busy_d  = 1'b0;
            dwell_d = '0;
          end else if (arb_sel == owner_q) begin
            dwell_d = DWELL_LOAD;
          end else begin
            owner_d = arb_sel;
            grant_d = sel_onehot;
            rr_d    = rr_after;
            dwell_d = DWELL_LOAD;
`ifdef LED_SHARE_ARB_OWNER_FLASH_EN
            state_d = FLASH;
            flash_d = FLASH_LOAD;
`endif
          end
        end else begin
          dwell_d = dwell_q - DWELL_W'(1);
        end
      end
`ifdef LED_SHARE_ARB_OWNER_FLASH_EN
      FLASH: begin
        led_d = 4'(owner_q) + 4'd1;
        if (!owner_req) begin
          if (!arb_found) begin
            state_d = IDLE;
            grant_d = '0;
            led_d   = '0;
            busy_d  = 1'b0;
            dwell_d = '0;
          end else begin
            owner_d = arb_sel;
            grant_d = sel_onehot;
            rr_d    = rr_after;
            flash_d = FLASH_LOAD;
          end
        end else if (flash_q == '0) begin
          state_d = SHOW;
          dwell_d = DWELL_LOAD;
        end else begin
          flash_d = flash_q - FLASH_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
        led_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      dwell_q <= '0;
`ifdef LED_SHARE_ARB_OWNER_FLASH_EN
      flash_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      dwell_q <= dwell_d;
`ifdef LED_SHARE_ARB_OWNER_FLASH_EN
      flash_q <= flash_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign led_out = led_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Scoreboard bench for led_share_arbiter: directed scenarios then random traffic against an ownership/age model.
module tb_led_share_arbiter;
  localparam int N     = 4;
  localparam int DWELL = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [4*N-1:0] req_val;
  logic [N-1:0]   grant;
  logic [3:0]     led_out;
  logic           busy;

  always #5 clk = ~clk;

  led_share_arbiter #(
    .NUM_CLIENTS(N), .DWELL_CYCLES(DWELL), .DWELL_W(3), .FLASH_CYCLES(3)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .req(req), .req_val(req_val),
    .grant(grant), .led_out(led_out), .busy(busy)
  );

  typedef struct packed {
    logic [N-1:0] grant;
    logic [3:0]   led;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Model: who owns the LEDs, how many cycles they have owned them, and where the next search starts
  int m_owner = -1;
  int m_age   = 0;
  int m_rr    = 0;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rstn, input logic [N-1:0] r, input logic [4*N-1:0] v,
                            output exp_t e);
    int nxt;
    logic [3:0] led;
    led = 4'h0;
    if (!rstn) begin
      m_owner = -1; m_age = 0; m_rr = 0;
    end else if (m_owner < 0) begin
      nxt = pick(r, m_rr);
      if (nxt >= 0) begin m_owner = nxt; m_age = 1; m_rr = (nxt + 1) % N; end
    end else begin
      led = v[4*m_owner +: 4];
      if (!r[m_owner] || m_age >= DWELL) begin
        nxt = pick(r, (m_owner + 1) % N);
        if (nxt < 0) begin m_owner = -1; led = 4'h0; end
        else begin m_owner = nxt; m_age = 1; m_rr = (nxt + 1) % N; end
      end else begin
        m_age++;
      end
    end
    e.grant = (m_owner < 0) ? '0 : N'(1 << m_owner);
    e.led   = led;
    e.busy  = (m_owner >= 0);
  endtask

  task automatic step(input logic rstn, input logic [N-1:0] r, input logic [4*N-1:0] v);
    exp_t e;
    @(negedge clk);
    rst_n = rstn; req = r; req_val = v;
    model_step(rstn, r, v, e);
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n, input logic [N-1:0] r, input logic [4*N-1:0] v);
    for (int i = 0; i < n; i++) step(1'b1, r, v);
  endtask

  logic [N-1:0] prev_grant = '0;

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared += 4;
      if (grant !== e.grant) begin
        mismatched++;
        $display("FAIL grant t=%0t got=%b want=%b", $time, grant, e.grant);
      end
      if (led_out !== e.led) begin
        mismatched++;
        $display("FAIL led_out t=%0t got=%h want=%h", $time, led_out, e.led);
      end
      if (busy !== e.busy) begin
        mismatched++;
        $display("FAIL busy t=%0t got=%b want=%b", $time, busy, e.busy);
      end
      if ($countones(grant) > 1) begin
        mismatched++;
        $display("FAIL grant_onehot t=%0t got=%b want=at most one bit", $time, grant);
      end
      if (grant !== prev_grant)
        $display("grant %b -> %b led=%h busy=%b t=%0t", prev_grant, grant, led_out, busy, $time);
      prev_grant = grant;
    end
  end

  initial begin
    logic [N-1:0]   r;
    logic [4*N-1:0] v;
    rst_n = 1'b0; req = '0; req_val = '0;
    // reset, then a single requester
    step(1'b0, 4'b0000, 16'h0000);
    step(1'b0, 4'b0000, 16'h0000);
    hold(6, 4'b0100, 16'h0A00);
    hold(3, 4'b0000, 16'h0A00);
    // everyone requesting: strict rotation
    hold(22, 4'b1111, 16'h8421);
    hold(2, 4'b0000, 16'h0000);
    // owner changes its pattern mid-dwell
    hold(2, 4'b0010, 16'h0030);
    hold(3, 4'b0010, 16'h00C0);
    hold(2, 4'b0000, 16'h0000);
    // owner drops early with another waiting, then with nobody waiting
    hold(2, 4'b0100, 16'h5600);
    hold(3, 4'b1000, 16'h5600);
    hold(2, 4'b0000, 16'h0000);
    hold(2, 4'b0100, 16'h0900);
    hold(2, 4'b0000, 16'h0900);
    // reset while client 3 owns, then priority restarts at client 0
    hold(3, 4'b1000, 16'hF000);
    step(1'b0, 4'b1000, 16'hF000);
    hold(6, 4'b1001, 16'h7002);
    // random traffic
    r = '0; v = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) r[i] = ~r[i];
      if ($urandom_range(3) == 0) v = 16'($urandom);
      step($urandom_range(299) != 0, r, v);
    end
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
